// File: rtl/logic_op_pkg.sv
// Shared opcode definitions for the logic_op pipeline.
// Provides the op_e encoding, OP_LAST and is_legal_op.
package logic_op_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5
  } op_e;

  localparam logic [2:0] OP_LAST = 3'd5;

  function automatic logic is_legal_op(
    input logic [2:0] op
  );
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/logic_op_fold.sv
// Combinational bitwise fold of NUM_IN operands.
// Ports: i_data (packed operands), i_op -> o_res, o_err.
module logic_op_fold
  import logic_op_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2
) (
  input  logic [NUM_IN*WIDTH-1:0] i_data,
  input  logic [2:0]              i_op,
  output logic [WIDTH-1:0]        o_res,
  output logic                    o_err
);

  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] w_xor;

  always_comb begin
    w_and = '1;
    w_or  = '0;
    w_xor = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_and = w_and & i_data[k*WIDTH +: WIDTH];
      w_or  = w_or  | i_data[k*WIDTH +: WIDTH];
      w_xor = w_xor ^ i_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    o_res = '0;
    o_err = 1'b0;
    unique case (1'b1)
      !is_legal_op(i_op): o_err = 1'b1;
      i_op == OP_AND:     o_res = w_and;
      i_op == OP_OR:      o_res = w_or;
      i_op == OP_XOR:     o_res = w_xor;
      i_op == OP_NAND:    o_res = ~w_and;
      i_op == OP_NOR:     o_res = ~w_or;
      i_op == OP_XNOR:    o_res = ~w_xor;
      default:            o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_op_pipe.sv
// STAGES-deep valid/ready pipeline around logic_op_fold.
// Ports: in_* upstream handshake, out_* result, txn_count.
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_op,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [2:0]              out_op,
  output logic                    out_err,
  output logic [CNT_W-1:0]        txn_count
);

  logic             w_adv;
  logic             w_acc;
  logic [WIDTH-1:0] w_res;
  logic             w_err;

  logic [STAGES-1:0] r_vld;
  logic [WIDTH-1:0]  r_data [STAGES];
  logic [2:0]        r_op   [STAGES];
  logic              r_err  [STAGES];
  logic [CNT_W-1:0]  r_cnt;

  logic_op_fold #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_fold (
    .i_data (in_data),
    .i_op   (in_op),
    .o_res  (w_res),
    .o_err  (w_err)
  );

  // One global enable: the whole pipe moves or holds.
  assign w_adv    = !r_vld[STAGES-1] || out_ready;
  assign in_ready = w_adv && !rst;
  assign w_acc    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_cnt <= '0;
      for (int s = 0; s < STAGES; s++) begin
        r_data[s] <= '0;
        r_op[s]   <= '0;
        r_err[s]  <= 1'b0;
      end
    end else begin
      if (w_adv) begin
        r_vld[0] <= w_acc;
        if (w_acc) begin
          r_data[0] <= w_res;
          r_op[0]   <= in_op;
          r_err[0]  <= w_err;
        end
        for (int s = 1; s < STAGES; s++) begin
          r_vld[s]  <= r_vld[s-1];
          r_data[s] <= r_data[s-1];
          r_op[s]   <= r_op[s-1];
          r_err[s]  <= r_err[s-1];
        end
      end
      if (r_vld[STAGES-1] && out_ready && r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_valid = r_vld[STAGES-1];
  assign out_data  = r_data[STAGES-1];
  assign out_op    = r_op[STAGES-1];
  assign out_err   = r_err[STAGES-1];
  assign txn_count = r_cnt;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Scoreboard bench for logic_op_pipe.
// WIDTH=4, NUM_IN=3, STAGES=2, CNT_W=4.
module tb_logic_op_pipe;

  localparam int W = 4;
  localparam int N = 3;
  localparam int S = 2;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = 3'd0;
  logic [N*W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic [2:0]   out_op;
  logic         out_err;
  logic [C-1:0] txn_count;

  typedef struct packed {
    logic [W-1:0] d;
    logic [2:0]   op;
    logic         err;
  } exp_t;

  exp_t         sb[$];
  int           pop_cyc[$];
  int           cyc = 0;
  int           n_vec = 0;
  int           n_miss = 0;
  logic [C-1:0] m_cnt = '0;

  logic_op_pipe #(
    .WIDTH  (W),
    .NUM_IN (N),
    .STAGES (S),
    .CNT_W  (C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_op    (out_op),
    .out_err   (out_err),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(
    input logic [2:0]     op,
    input logic [N*W-1:0] d
  );
    logic [W-1:0] a;
    logic [W-1:0] o;
    logic [W-1:0] x;
    exp_t e;
    a = '1;
    o = '0;
    x = '0;
    for (int k = 0; k < N; k++) begin
      a = a & d[k*W +: W];
      o = o | d[k*W +: W];
      x = x ^ d[k*W +: W];
    end
    e.op  = op;
    e.err = 1'b0;
    case (op)
      3'd0: e.d = a;
      3'd1: e.d = o;
      3'd2: e.d = x;
      3'd3: e.d = ~a;
      3'd4: e.d = ~o;
      3'd5: e.d = ~x;
      default: begin
        e.d   = '0;
        e.err = 1'b1;
      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    chk("txn_count", 32'(txn_count), 32'(m_cnt));
    if (rst) begin
      chk("in_ready_rst", 32'(in_ready), 0);
      sb.delete();
      m_cnt = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_op", 32'(out_op), 32'(e.op));
          chk("out_err", 32'(out_err), 32'(e.err));
          pop_cyc.push_back(cyc);
        end
        if (m_cnt != '1) m_cnt++;
      end
      if (in_valid && in_ready)
        sb.push_back(model(in_op, in_data));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after accept.
  task automatic send(
    input logic [2:0]     op,
    input logic [N*W-1:0] d
  );
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_op", 32'(out_op), 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_txn", 32'(txn_count), 0);
    step();

    send(3'd0, {4'h6, 4'hC, 4'hF});
    @(negedge clk);
    chk("lat1_valid", 32'(out_valid), 0);
    @(negedge clk);
    chk("lat2_valid", 32'(out_valid), 1);
    chk("and_data", 32'(out_data), 32'h4);
    chk("and_err", 32'(out_err), 0);
    @(negedge clk);
    chk("and_txn", 32'(txn_count), 1);
    step();

    pop_cyc.delete();
    for (int op = 0; op < 6; op++)
      send(3'(op), {4'h3, 4'h6, 4'hA});
    drain();
    chk("sweep_n", 32'(pop_cyc.size()), 6);
    for (int i = 1; i < 6 && i < pop_cyc.size(); i++)
      chk("sweep_b2b", 32'(pop_cyc[i] - pop_cyc[0]), 32'(i));

    send(3'd7, {4'hF, 4'hF, 4'hF});
    drain();

    out_ready = 1'b0;
    send(3'd1, {4'h1, 4'h2, 4'h4});
    send(3'd2, {4'h8, 4'h3, 4'h5});
    in_valid = 1'b1;
    in_op    = 3'd3;
    in_data  = {4'h9, 4'hB, 4'hF};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
      if (sb.size() > 0) begin
        chk("bp_out_data", 32'(out_data), 32'(sb[0].d));
        chk("bp_out_op", 32'(out_op), 32'(sb[0].op));
      end
    end
    step();
    out_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("bp_accept_timeout", 1, 0);
    step();
    in_valid = 1'b0;
    drain();

    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++)
      send(3'($urandom_range(0, 7)), 12'($urandom));
    drain();
    @(negedge clk);
    chk("sat_txn", 32'(txn_count), 15);
    step();

    rst = 1'b1;
    step();
    rst = 1'b0;
    send(3'd0, {4'hF, 4'hF, 4'hF});
    send(3'd1, {4'h1, 4'h0, 4'h0});
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_txn", 32'(txn_count), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
